// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and
// the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from a 3-to-8 minterm decoder; sum and carry are
// ORs over the minterms in which each output is true.
module full_adder (
    input  logic in1_i,
    input  logic in2_i,
    input  logic c_in_i,
    output logic sum_o,
    output logic c_out_o
);

    localparam logic [7:0] SUM_MINTERMS   = 8'b1001_0110;  // indices 1,2,4,7
    localparam logic [7:0] CARRY_MINTERMS = 8'b1110_1000;  // indices 3,5,6,7

    logic [2:0] index;
    logic [7:0] minterm;

    assign index   = {in1_i, in2_i, c_in_i};
    assign minterm = 8'(1) << index;

    assign sum_o   = |(minterm & SUM_MINTERMS);
    assign c_out_o = |(minterm & CARRY_MINTERMS);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB-first through a single full-adder
// slice, one bit per clock, and the completed result is published in DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_adder u_full_adder (
        .in1_i   (a_q[0]),
        .in2_i   (b_q[0]),
        .c_in_i  (carry_q),
        .sum_o   (fa_sum),
        .c_out_o (fa_carry)
    );

    // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign res_d    = {fa_sum, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_LAST);
    assign cnt_d    = last_bit ? '0 : cnt_q + CNT_W'(1);

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; blocking assignments would let the shift registers
    // see each other's new contents within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_carry;
                    res_q   <= res_d;
                    cnt_q   <= cnt_d;
                    if (last_bit) begin
                        sum_q   <= res_d;
                        c_out_q <= fa_carry;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int           checks   = 0;
    int           failures = 0;
    logic [W:0]   last_res;   // {c_out,sum} the outputs must currently hold

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
        return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the start edge. Operands
    // are scrambled right after it to show they are not re-sampled.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        c_in  = cv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        c_in  = 1'($urandom);
    endtask

    // Returns at the negedge where done is seen (or after the cycle budget).
    task automatic wait_done(input string tag, input logic [W:0] exp_res);
        int lat      = 0;
        int busy_cnt = 0;
        bit seen     = 0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            lat = cyc;
            if (done) begin
                seen = 1;
            end else begin
                busy_cnt += int'(busy);
                check({tag, "_hold"}, 32'({c_out, sum}), 32'(last_res));
            end
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_cnt, W);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_result"}, 32'({c_out, sum}), 32'(exp_res));
        last_res = exp_res;
    endtask

    initial begin
        int dn;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;
        last_res = '0;

        #12;
        check("reset_busy",  32'(busy),  0);
        check("reset_done",  32'(done),  0);
        check("reset_sum",   32'(sum),   0);
        check("reset_c_out", 32'(c_out), 0);

        @(negedge clk);
        rst = 1'b0;

        // First start right after reset release, then the basic example.
        launch(8'h5A, 8'h3C, 1'b0);
        check("first_start_busy", 32'(busy), 1);
        wait_done("5a_3c", model(8'h5A, 8'h3C, 1'b0));
        @(negedge clk);
        check("done_single_cycle", 32'(done), 0);

        launch(8'hFF, 8'h01, 1'b0);
        wait_done("ff_01", 9'h100);
        launch(8'hFF, 8'hFF, 1'b1);
        wait_done("ff_ff_c1", 9'h1FF);
        @(negedge clk);

        // start held through RUN while operands change must not disturb the op.
        start = 1'b1;
        a     = 8'h81;
        b     = 8'h92;
        c_in  = 1'b1;
        @(posedge clk);
        #1;
        a    = 8'h00;
        b    = 8'h00;
        c_in = 1'b0;
        repeat (7) @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) begin
                dn++;
                check("held_start_result", 32'({c_out, sum}), 32'(model(8'h81, 8'h92, 1'b1)));
            end
        end
        check("held_start_done_pulses", dn, 1);
        last_res = model(8'h81, 8'h92, 1'b1);

        // Reset in the middle of RUN aborts the op and clears the outputs.
        launch(8'h12, 8'h34, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy",  32'(busy),  0);
        check("abort_done",  32'(done),  0);
        check("abort_sum",   32'(sum),   0);
        check("abort_c_out", 32'(c_out), 0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        launch(8'h12, 8'h34, 1'b0);
        wait_done("after_abort", 9'h046);
        @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle of the first.
        launch(8'h01, 8'h02, 1'b0);
        wait_done("b2b_first", 9'h003);
        launch(8'h10, 8'h20, 1'b0);
        wait_done("b2b_second", 9'h030);

        // Random operations with random gaps (a gap of 0 is back-to-back).
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(ra, rb, rc);
            wait_done("rand", model(ra, rb, rc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
